gnr_node_lut: RTL and testbench

Parametrised Boolean-network node for the GNR accelerator: the successor to the fixed-expression, two-copy node blocks. Each node holds `NUM_TRACKS` independent 1-bit state copies for attractor detection, for example a slow track and a fast track. Each copy's next value is a truth-table lookup over `NUM_IN` regulator inputs. Track 0 advances once every `SLOW_DIV` update strobes, which generalises the fixed divide-by-two slow track.

---
 rtl/gnr_node_lut.sv | 93 +++++++++
 tb/tb_gnr_node_lut.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/gnr_node_lut.sv
// gnr_node_lut: Boolean-network node with NUM_TRACKS independent 1-bit state
// copies, each advanced by a truth-table lookup over NUM_IN regulator inputs.
// Track 0 advances once every SLOW_DIV strobes (slow track for attractor
// detection); all other tracks advance on every strobe.
// Optional feature macro: GNR_LUT_CFG_EN adds a runtime-writable truth table
// (cfg_we/cfg_addr/cfg_data); without it the table is the constant LUT_INIT.
module gnr_node_lut #(
  parameter int                   NUM_IN     = 4,
  parameter int                   NUM_TRACKS = 2,
  parameter int                   SLOW_DIV   = 2,
  parameter logic [2**NUM_IN-1:0] LUT_INIT   = 16'hAAAA
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         reset_nos,
  input  logic                         init_state,
  input  logic [NUM_TRACKS-1:0]        start,
  input  logic [NUM_TRACKS*NUM_IN-1:0] in_state,
`ifdef GNR_LUT_CFG_EN
  input  logic                         cfg_we,
  input  logic [NUM_IN-1:0]            cfg_addr,
  input  logic                         cfg_data,
`endif
  output logic [NUM_TRACKS-1:0]        state,
  output logic [NUM_TRACKS-1:0]        changed,
  output logic                         match
);

  localparam int LUT_N = 2**NUM_IN;
  localparam int CNT_W = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOW_DIV - 1);

  logic [LUT_N-1:0]      lut;
  logic [CNT_W-1:0]      cnt;
  logic [NUM_TRACKS-1:0] nxt;
  logic [NUM_TRACKS-1:0] upd;

`ifdef GNR_LUT_CFG_EN
  // Writable truth table; a write lands at the edge, so a same-cycle lookup
  // still sees the old bit. reset_nos deliberately leaves it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lut <= LUT_INIT;
    end else if (cfg_we) begin
      lut[cfg_addr] <= cfg_data;
    end
  end
`else
  assign lut = LUT_INIT;
`endif

  // Per-track lookup of the next state from that track's input slice.
  always_comb begin
    nxt = '0;
    for (int t = 0; t < NUM_TRACKS; t++) begin
      nxt[t] = lut[in_state[t*NUM_IN +: NUM_IN]];
    end
  end

  // Track 0 only updates on the strobe that completes its divider period.
  always_comb begin
    upd    = start;
    upd[0] = start[0] && (cnt == CNT_MAX);
  end

  // State, change pulses and slow-track divider. A reload parks the divider
  // at its terminal count so the first strobe afterwards updates track 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= '0;
      changed <= '0;
      cnt     <= '0;
    end else if (reset_nos) begin
      state   <= {NUM_TRACKS{init_state}};
      changed <= '0;
      cnt     <= CNT_MAX;
    end else begin
      for (int t = 0; t < NUM_TRACKS; t++) begin
        changed[t] <= upd[t] && (nxt[t] != state[t]);
        if (upd[t]) begin
          state[t] <= nxt[t];
        end
      end
      if (start[0]) begin
        cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
      end
    end
  end

  // Slow and fast copies agree; trivially true for a single track.
  assign match = (state[0] == state[NUM_TRACKS-1]);

endmodule

// File: tb/tb_gnr_node_lut.sv
// Directed bench for gnr_node_lut: three instances sharing stimulus, all with
// a 2-input AND truth table and SLOW_DIV of 1, 2 and 3 respectively.
module tb_gnr_node_lut;

  logic       clk = 1'b0;
  logic       rst;
  logic       reset_nos;
  logic       init_state;
  logic [1:0] start;
  logic [3:0] in_state;
`ifdef GNR_LUT_CFG_EN
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic       cfg_data;
`endif
  logic [1:0] a_state, a_changed, b_state, b_changed, c_state, c_changed;
  logic       a_match, b_match, c_match;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gnr_node_lut #(.NUM_IN(2), .NUM_TRACKS(2), .SLOW_DIV(1), .LUT_INIT(4'b1000)) u_a (
    .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state),
    .start(start), .in_state(in_state),
`ifdef GNR_LUT_CFG_EN
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
`endif
    .state(a_state), .changed(a_changed), .match(a_match));

  gnr_node_lut #(.NUM_IN(2), .NUM_TRACKS(2), .SLOW_DIV(2), .LUT_INIT(4'b1000)) u_b (
    .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state),
    .start(start), .in_state(in_state),
`ifdef GNR_LUT_CFG_EN
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
`endif
    .state(b_state), .changed(b_changed), .match(b_match));

  gnr_node_lut #(.NUM_IN(2), .NUM_TRACKS(2), .SLOW_DIV(3), .LUT_INIT(4'b1000)) u_c (
    .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state),
    .start(start), .in_state(in_state),
`ifdef GNR_LUT_CFG_EN
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
`endif
    .state(c_state), .changed(c_changed), .match(c_match));

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // SLOW_DIV pulse sequence: four consecutive start[0] with next=1
  logic [1:0] exp_b_st [4] = '{2'b00, 2'b01, 2'b01, 2'b01};
  logic [1:0] exp_b_ch [4] = '{2'b00, 2'b01, 2'b00, 2'b00};
  logic [1:0] exp_c_st [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
  logic [1:0] exp_c_ch [4] = '{2'b00, 2'b00, 2'b01, 2'b00};
  logic [1:0] exp_c_cn [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
  logic [1:0] exp_a_st [4] = '{2'b01, 2'b01, 2'b01, 2'b01};
  logic [1:0] exp_a_ch [4] = '{2'b01, 2'b00, 2'b00, 2'b00};

  // SLOW_DIV=3 with both strobes every cycle, track 1 next toggling 0/1
  logic [1:0] exp_e_st [6] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b11};
  logic [1:0] exp_e_ch [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11};
  logic [1:0] exp_e_cn [6] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
  logic       exp_e_mt [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; reset_nos = 1'b0; init_state = 1'b0; start = 2'b00; in_state = 4'b0000;
`ifdef GNR_LUT_CFG_EN
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 1'b0;
`endif
    step(); step();
    check("rst_a_state", a_state, 2'b00);
    check("rst_a_changed", a_changed, 2'b00);
    check("rst_a_match", {1'b0, a_match}, 2'b01);
    check("rst_c_cnt", u_c.cnt, 2'd0);
    rst = 1'b1;

    // Both tracks of the undivided node update together through AND
    in_state = 4'b1111; start = 2'b11;
    step();
    start = 2'b00;
    check("and_a_state", a_state, 2'b11);
    check("and_a_changed", a_changed, 2'b11);
    check("and_a_match", {1'b0, a_match}, 2'b01);
    check("and_b_state", b_state, 2'b10);
    check("and_b_changed", b_changed, 2'b10);

    // Asynchronous reset mid-run clears without a clock edge
    rst = 1'b0;
    #1;
    check("arst_a_state", a_state, 2'b00);
    check("arst_a_changed", a_changed, 2'b00);
    check("arst_b_state", b_state, 2'b00);
    check("arst_c_cnt", u_c.cnt, 2'd0);
    #2 rst = 1'b1;

    // Four start[0] strobes after reset
    in_state = 4'b1111; start = 2'b01;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("div_b_state%0d", k), b_state, exp_b_st[k]);
      check($sformatf("div_b_changed%0d", k), b_changed, exp_b_ch[k]);
      check($sformatf("div_c_state%0d", k), c_state, exp_c_st[k]);
      check($sformatf("div_c_changed%0d", k), c_changed, exp_c_ch[k]);
      check($sformatf("div_c_cnt%0d", k), u_c.cnt, exp_c_cn[k]);
      check($sformatf("div_a_state%0d", k), a_state, exp_a_st[k]);
      check($sformatf("div_a_changed%0d", k), a_changed, exp_a_ch[k]);
    end

    // Reload wins over simultaneous strobes
    reset_nos = 1'b1; init_state = 1'b1; start = 2'b11; in_state = 4'b0000;
    step();
    reset_nos = 1'b0; init_state = 1'b0; start = 2'b00;
    check("nos_a_state", a_state, 2'b11);
    check("nos_b_state", b_state, 2'b11);
    check("nos_c_state", c_state, 2'b11);
    check("nos_b_changed", b_changed, 2'b00);
    check("nos_c_cnt", u_c.cnt, 2'd2);

    // First start[0] after a reload updates the slow track at once
    start = 2'b01; in_state = 4'b0000;
    step();
    start = 2'b00;
    check("nos1_b_state", b_state, 2'b10);
    check("nos1_b_changed", b_changed, 2'b01);
    check("nos1_c_state", c_state, 2'b10);
    check("nos1_c_changed", c_changed, 2'b01);
    check("nos1_c_cnt", u_c.cnt, 2'd0);

    // Divide-by-3 slow track against an every-strobe fast track
    start = 2'b11;
    for (int k = 0; k < 6; k++) begin
      in_state = (k % 2 == 0) ? 4'b0000 : 4'b1111;
      step();
      check($sformatf("ratio_c_state%0d", k), c_state, exp_e_st[k]);
      check($sformatf("ratio_c_changed%0d", k), c_changed, exp_e_ch[k]);
      check($sformatf("ratio_c_cnt%0d", k), u_c.cnt, exp_e_cn[k]);
      check($sformatf("ratio_c_match%0d", k), {1'b0, c_match}, {1'b0, exp_e_mt[k]});
    end
    start = 2'b00;

`ifdef GNR_LUT_CFG_EN
    // Same-cycle table write: lookup sees the old bit, next strobe the new one
    in_state = 4'b0000; start = 2'b10;
    step();
    check("cfg_pre_state", a_state, 2'b01);
    in_state = 4'b1111; cfg_we = 1'b1; cfg_addr = 2'd3; cfg_data = 1'b0;
    step();
    cfg_we = 1'b0;
    check("cfg_old_bit", a_state, 2'b11);
    step();
    start = 2'b00;
    check("cfg_new_bit", a_state, 2'b01);
    check("cfg_new_changed", a_changed, 2'b10);
`endif

    // Reset restores the truth table
    rst = 1'b0;
    #2 rst = 1'b1;
    in_state = 4'b1111; start = 2'b10;
    step();
    start = 2'b00;
    check("lut_restore_state", a_state, 2'b10);
    check("lut_restore_match", {1'b0, a_match}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
